// File: rtl/armaria_stack_pkg.sv
// Shared address map, stack-op encoding and depth width for the SP/PC bank.
package armaria_stack_pkg;

  localparam int DEPTH_WIDTH = 12;

  localparam int unsigned PRIV_STACK_TOP    = 4096;
  localparam int unsigned PRIV_STACK_BOTTOM = 6143;
  localparam int unsigned USER_STACK_TOP    = 6144;
  localparam int unsigned USER_STACK_BOTTOM = 8191;
  localparam logic [31:0] SP_EMPTY          = 32'hffff_ffff;

  typedef enum logic [1:0] {
    STACK_NONE = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2,
    STACK_RSVD = 2'd3
  } stack_op_e;

endpackage

// File: rtl/sp_bank_entry.sv
// One stack bank: SP register, depth counter, expected-next-SP and range checks.
module sp_bank_entry #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WIDTH = 12,
  parameter int                    SIZE        = 2048,
  parameter logic [DATA_WIDTH-1:0] TOP         = DATA_WIDTH'(6144),
  parameter logic [DATA_WIDTH-1:0] BOTTOM      = DATA_WIDTH'(8191),
  parameter logic [DATA_WIDTH-1:0] EMPTY       = '1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   upd,
  input  logic [1:0]             stack_op,
  input  logic [DATA_WIDTH-1:0]  next_sp,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic [DATA_WIDTH-1:0]  sp,
  output logic [DEPTH_WIDTH-1:0] depth,
  output logic                   ovf_strb,
  output logic                   udf_strb,
  output logic                   mis_strb
);
  import armaria_stack_pkg::*;

  localparam logic [DEPTH_WIDTH-1:0] SIZE_D = DEPTH_WIDTH'(SIZE);
  localparam logic [DEPTH_WIDTH-1:0] ONE_D  = DEPTH_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  ONE_W  = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  sp_q, sp_nxt, exp_sp, wr_depth;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_nxt;
  logic                   wr_in_range;

  assign wr_in_range = (wr_data >= TOP) && (wr_data <= BOTTOM);
  assign wr_depth    = BOTTOM - wr_data + ONE_W;

  always_comb begin
    sp_nxt    = sp_q;
    depth_nxt = depth_q;
    exp_sp    = '0;
    ovf_strb  = 1'b0;
    udf_strb  = 1'b0;
    mis_strb  = 1'b0;
    if (upd) begin
      // explicit write shadows any stack op issued alongside it
      if (wr_en) begin
        if (wr_data == EMPTY) begin
          sp_nxt    = EMPTY;
          depth_nxt = '0;
        end else if (wr_in_range) begin
          sp_nxt    = wr_data;
          depth_nxt = wr_depth[DEPTH_WIDTH-1:0];
        end else begin
          mis_strb  = 1'b1;
        end
      end else if (stack_op == STACK_PUSH) begin
        exp_sp = (sp_q == EMPTY) ? BOTTOM : sp_q - ONE_W;
        if (depth_q == SIZE_D) begin
          ovf_strb = 1'b1;
        end else begin
          sp_nxt    = next_sp;
          depth_nxt = depth_q + ONE_D;
          mis_strb  = (next_sp != exp_sp);
        end
      end else if (stack_op == STACK_POP) begin
        exp_sp = (depth_q == ONE_D) ? EMPTY : sp_q + ONE_W;
        if (depth_q == '0) begin
          udf_strb = 1'b1;
        end else begin
          sp_nxt    = next_sp;
          depth_nxt = depth_q - ONE_D;
          mis_strb  = (next_sp != exp_sp);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q    <= EMPTY;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_nxt;
      depth_q <= depth_nxt;
    end
  end

  assign sp    = sp_q;
  assign depth = depth_q;

endmodule

// File: rtl/sp_pc_bank.sv
// Architectural PC plus banked user/privileged SPs wrapped around the address handler.
module sp_pc_bank #(
  parameter int                    DATA_WIDTH            = 32,
  parameter int                    ADDR_WIDTH            = 14,
  parameter int                    CODE_AREA_SIZE        = 4096,
  parameter int                    PRIVILEGED_STACK_SIZE = 2048,
  parameter int                    USER_STACK_SIZE       = 2048,
  parameter logic [DATA_WIDTH-1:0] EMPTY_SP              = '1,
  parameter int                    DEPTH_WIDTH           = armaria_stack_pkg::DEPTH_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   privilege_mode_flag,
  input  logic [1:0]             stack_op,
  input  logic [DATA_WIDTH-1:0]  next_SP_in,
  input  logic [ADDR_WIDTH-1:0]  next_PC_in,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   sp_write_en,
  input  logic [DATA_WIDTH-1:0]  sp_write_data,
  input  logic                   clear_faults,
  output logic [ADDR_WIDTH-1:0]  current_PC,
  output logic [DATA_WIDTH-1:0]  current_SP,
  output logic [DATA_WIDTH-1:0]  user_SP,
  output logic [DATA_WIDTH-1:0]  privileged_SP,
  output logic [DEPTH_WIDTH-1:0] stack_depth,
  output logic                   stack_overflow,
  output logic                   stack_underflow,
  output logic                   sp_mismatch,
  output logic                   fault_pulse
);
  import armaria_stack_pkg::*;

  localparam int NUM_BANKS = 2;  // index 0 = user, 1 = privileged

  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_sp;
  logic [NUM_BANKS-1:0][DEPTH_WIDTH-1:0] bank_depth;
  logic [NUM_BANKS-1:0]                  bank_sel, ovf_strb, udf_strb, mis_strb;
  logic                                  any_ovf, any_udf, any_mis;

  assign bank_sel = {privilege_mode_flag, ~privilege_mode_flag};

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    localparam int SIZE = (g == 1) ? PRIVILEGED_STACK_SIZE : USER_STACK_SIZE;
    localparam int TOP  = (g == 1) ? CODE_AREA_SIZE : CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE;
    sp_bank_entry #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WIDTH (DEPTH_WIDTH),
      .SIZE        (SIZE),
      .TOP         (DATA_WIDTH'(TOP)),
      .BOTTOM      (DATA_WIDTH'(TOP + SIZE - 1)),
      .EMPTY       (EMPTY_SP)
    ) u_entry (
      .clock    (clock),
      .reset    (reset),
      .upd      (enable & bank_sel[g]),
      .stack_op (stack_op),
      .next_sp  (next_SP_in),
      .wr_en    (sp_write_en),
      .wr_data  (sp_write_data),
      .sp       (bank_sp[g]),
      .depth    (bank_depth[g]),
      .ovf_strb (ovf_strb[g]),
      .udf_strb (udf_strb[g]),
      .mis_strb (mis_strb[g])
    );
  end

  assign any_ovf = |ovf_strb;
  assign any_udf = |udf_strb;
  assign any_mis = |mis_strb;

  // strobes are already gated by enable, so a stall naturally drops the pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      current_PC      <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      sp_mismatch     <= 1'b0;
      fault_pulse     <= 1'b0;
    end else begin
      if (enable) current_PC <= branch_taken ? branch_target : next_PC_in;
      stack_overflow  <= any_ovf | (stack_overflow  & ~clear_faults);
      stack_underflow <= any_udf | (stack_underflow & ~clear_faults);
      sp_mismatch     <= any_mis | (sp_mismatch     & ~clear_faults);
      fault_pulse     <= any_ovf | any_udf | any_mis;
    end
  end

  assign user_SP       = bank_sp[0];
  assign privileged_SP = bank_sp[1];
  assign current_SP    = privilege_mode_flag ? bank_sp[1] : bank_sp[0];
  assign stack_depth   = privilege_mode_flag ? bank_depth[1] : bank_depth[0];

endmodule

// File: tb/tb_sp_pc_bank.sv
// Directed bench for sp_pc_bank with hand-computed expectations.
module tb_sp_pc_bank;
  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        privilege_mode_flag;
  logic [1:0]  stack_op;
  logic [31:0] next_SP_in;
  logic [13:0] next_PC_in;
  logic        branch_taken;
  logic [13:0] branch_target;
  logic        sp_write_en;
  logic [31:0] sp_write_data;
  logic        clear_faults;
  logic [13:0] current_PC;
  logic [31:0] current_SP, user_SP, privileged_SP;
  logic [11:0] stack_depth;
  logic        stack_overflow, stack_underflow, sp_mismatch, fault_pulse;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [31:0] EMP = 32'hffff_ffff;

  sp_pc_bank dut (
    .clock(clock), .reset(reset), .enable(enable),
    .privilege_mode_flag(privilege_mode_flag), .stack_op(stack_op),
    .next_SP_in(next_SP_in), .next_PC_in(next_PC_in),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .sp_write_en(sp_write_en), .sp_write_data(sp_write_data),
    .clear_faults(clear_faults), .current_PC(current_PC),
    .current_SP(current_SP), .user_SP(user_SP), .privileged_SP(privileged_SP),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .sp_mismatch(sp_mismatch),
    .fault_pulse(fault_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stack_op     = 2'd0;
    sp_write_en  = 1'b0;
    clear_faults = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic o, input logic u, input logic m, input logic p);
    chk({tag, ".ovf"}, {31'd0, stack_overflow},  {31'd0, o});
    chk({tag, ".udf"}, {31'd0, stack_underflow}, {31'd0, u});
    chk({tag, ".mis"}, {31'd0, sp_mismatch},     {31'd0, m});
    chk({tag, ".pls"}, {31'd0, fault_pulse},     {31'd0, p});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; privilege_mode_flag = 1'b0;
    next_SP_in = '0; next_PC_in = '0; branch_target = '0;
    sp_write_data = '0;
    idle();
    step(); step();
    reset = 1'b0;

    // reset mid-push
    next_PC_in = 14'd5; stack_op = 2'd1; next_SP_in = 32'd8191;
    step();
    chk("pre_rst_sp", current_SP, 32'd8191);
    chk("pre_rst_pc", {18'd0, current_PC}, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_sp", current_SP, EMP);
    step();
    idle(); next_PC_in = '0;
    reset = 1'b0;
    chk("rst_pc", {18'd0, current_PC}, 32'd0);
    chk("rst_depth", {20'd0, stack_depth}, 32'd0);
    chk("rst_usp", user_SP, EMP);
    chk("rst_psp", privileged_SP, EMP);
    chk_flags("rst", 0, 0, 0, 0);

    // user push/push/pop
    stack_op = 2'd1; next_SP_in = 32'd8191; step();
    chk("u_push1_sp", current_SP, 32'd8191);
    chk("u_push1_d", {20'd0, stack_depth}, 32'd1);
    next_SP_in = 32'd8190; step();
    chk("u_push2_sp", current_SP, 32'd8190);
    chk("u_push2_d", {20'd0, stack_depth}, 32'd2);
    stack_op = 2'd2; next_SP_in = 32'd8191; step();
    chk("u_pop_sp", current_SP, 32'd8191);
    chk("u_pop_d", {20'd0, stack_depth}, 32'd1);
    next_SP_in = EMP; step();
    chk("u_pop_empty_sp", current_SP, EMP);
    chk("u_pop_empty_d", {20'd0, stack_depth}, 32'd0);
    chk_flags("u_seq", 0, 0, 0, 0);

    // privileged fill to overflow
    privilege_mode_flag = 1'b1; stack_op = 2'd1;
    for (int i = 0; i < 2048; i++) begin
      next_SP_in = 32'd6143 - 32'(i);
      step();
    end
    chk("p_full_sp", current_SP, 32'd4096);
    chk("p_full_d", {20'd0, stack_depth}, 32'd2048);
    chk_flags("p_full", 0, 0, 0, 0);
    next_SP_in = 32'd4095; step();
    chk("p_ovf_sp", current_SP, 32'd4096);
    chk("p_ovf_d", {20'd0, stack_depth}, 32'd2048);
    chk("p_ovf_usp", user_SP, EMP);
    chk_flags("p_ovf", 1, 0, 0, 1);
    idle(); step();
    chk_flags("p_ovf_after", 1, 0, 0, 0);

    // clear collides with a fresh overflow: fault wins
    stack_op = 2'd1; clear_faults = 1'b1; step();
    chk_flags("clr_vs_ovf", 1, 0, 0, 1);
    idle(); clear_faults = 1'b1; step();
    idle();
    chk_flags("clr", 0, 0, 0, 0);

    // user underflow then mismatched push
    privilege_mode_flag = 1'b0;
    stack_op = 2'd2; next_SP_in = 32'd8191; step();
    chk("u_udf_d", {20'd0, stack_depth}, 32'd0);
    chk("u_udf_sp", current_SP, EMP);
    chk_flags("u_udf", 0, 1, 0, 1);
    stack_op = 2'd1; next_SP_in = 32'd8000; step();
    chk("u_mis_sp", current_SP, 32'd8000);
    chk("u_mis_d", {20'd0, stack_depth}, 32'd1);
    chk("u_mis_psp", privileged_SP, 32'd4096);
    chk_flags("u_mis", 0, 1, 1, 1);
    idle(); clear_faults = 1'b1; step(); idle();

    // explicit writes
    sp_write_en = 1'b1; sp_write_data = 32'd6000; stack_op = 2'd1; next_SP_in = 32'd7999;
    step();
    chk("w6000_sp", current_SP, 32'd8000);
    chk("w6000_d", {20'd0, stack_depth}, 32'd1);
    chk_flags("w6000", 0, 0, 1, 1);
    stack_op = 2'd0; sp_write_data = 32'd7000; step();
    chk("w7000_sp", current_SP, 32'd7000);
    chk("w7000_d", {20'd0, stack_depth}, 32'd1192);
    chk("w7000_pls", {31'd0, fault_pulse}, 32'd0);
    sp_write_data = 32'd6144; step();
    chk("w6144_d", {20'd0, stack_depth}, 32'd2048);
    sp_write_data = 32'd8191; step();
    chk("w8191_d", {20'd0, stack_depth}, 32'd1);
    sp_write_data = 32'd8192; step();
    chk("w8192_sp", current_SP, 32'd8191);
    chk("w8192_pls", {31'd0, fault_pulse}, 32'd1);
    sp_write_data = EMP; step();
    chk("wemp_sp", current_SP, EMP);
    chk("wemp_d", {20'd0, stack_depth}, 32'd0);
    chk("w_psp", privileged_SP, 32'd4096);
    idle();

    // PC stall / branch, and clear under stall
    next_PC_in = 14'd42; step();
    chk("pc_inc", {18'd0, current_PC}, 32'd42);
    enable = 1'b0; branch_taken = 1'b1; branch_target = 14'd100;
    stack_op = 2'd1; next_SP_in = 32'd8191; step();
    chk("pc_stall", {18'd0, current_PC}, 32'd42);
    chk("stall_sp", current_SP, EMP);
    chk_flags("stall", 0, 0, 1, 0);
    stack_op = 2'd0; clear_faults = 1'b1; step();
    chk_flags("stall_clr", 0, 0, 0, 0);
    clear_faults = 1'b0; enable = 1'b1; step();
    chk("pc_branch", {18'd0, current_PC}, 32'd100);
    idle(); step();
    chk("pc_after", {18'd0, current_PC}, 32'd42);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/sp_pc_bank.md
Name: sp_pc_bank

Overview:
Architectural PC and banked stack-pointer register stage. It sits directly around the memory address handler: it drives that block's current_PC and current_SP, and registers the next_PC and next_SP values the handler computes. It keeps separate user and privileged SPs with per-bank depth counters. It blocks illegal stack updates and flags overflow, underflow and SP-math mismatches.

Parameters:
DATA_WIDTH, 32, SP and data width
ADDR_WIDTH, 14, PC width
CODE_AREA_SIZE, 4096, first privileged stack address (privileged top)
PRIVILEGED_STACK_SIZE, 2048, privileged stack words; privileged bottom = 6143
USER_STACK_SIZE, 2048, user stack words; user top = 6144, user bottom = 8191
EMPTY_SP, 32'hffffffff, empty-stack sentinel
DEPTH_WIDTH, 12, depth counter width (holds 0..2048)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  0 = stall; no register updates
privilege_mode_flag  input  1  1 = privileged bank selected
stack_op  input  2  0 none, 1 push, 2 pop, 3 reserved (treated as none)
next_SP_in  input  DATA_WIDTH  next SP from the address handler
next_PC_in  input  ADDR_WIDTH  incremented PC from the address handler
branch_taken  input  1  load branch_target instead of next_PC_in
branch_target  input  ADDR_WIDTH  branch destination
sp_write_en  input  1  explicit write of the selected SP
sp_write_data  input  DATA_WIDTH  explicit SP value
clear_faults  input  1  clears the sticky fault flags
current_PC  output  ADDR_WIDTH  registered PC
current_SP  output  DATA_WIDTH  selected bank SP (combinational mux of registers)
user_SP  output  DATA_WIDTH  user bank register
privileged_SP  output  DATA_WIDTH  privileged bank register
stack_depth  output  DEPTH_WIDTH  selected bank depth
stack_overflow  output  1  sticky
stack_underflow  output  1  sticky
sp_mismatch  output  1  sticky
fault_pulse  output  1  one-cycle pulse on any new fault

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - current_PC = 0
  - both SPs = EMPTY_SP; both depths = 0
  - all fault flags and fault_pulse = 0
- Bank select: privilege_mode_flag is sampled combinationally each cycle. The unselected bank never changes.
- enable = 0:
  - all registers hold; fault_pulse = 0
  - clear_faults is still honoured
- PC (enable = 1), updated every cycle with 1-cycle latency:
  - branch_taken = 1: PC <= branch_target
  - otherwise: PC <= next_PC_in
- Priority: sp_write_en > stack_op. A stack_op in the same cycle as sp_write_en is ignored and raises no fault.
- Push, selected bank depth d, top T, bottom B:
  - d == size: overflow. SP and depth unchanged, stack_overflow set, fault_pulse.
  - else: SP <= next_SP_in, d <= d+1.
  - Expected next_SP_in is B when SP == EMPTY_SP, otherwise SP-1. On disagreement, sp_mismatch is set and fault_pulse fires, but the update still happens.
- Pop:
  - d == 0: underflow. SP and depth unchanged, stack_underflow set, fault_pulse.
  - else: SP <= next_SP_in, d <= d-1.
  - Expected next_SP_in is EMPTY_SP when d == 1, otherwise SP+1. Mismatch handled as for push.
- Explicit write:
  - data == EMPTY_SP: SP <= EMPTY_SP, depth 0.
  - T <= data <= B: SP <= data, depth <= B - data + 1.
  - otherwise: write rejected, sp_mismatch set, fault_pulse.
- clear_faults:
  - clears all three sticky flags that cycle.
  - A fault arising in the same cycle wins: its flag is set and pulsed.
- Width rules:
  - depth arithmetic is DEPTH_WIDTH bits, unsigned.
  - range compares use the full DATA_WIDTH.
  - depth never wraps because of the overflow and underflow guards.

Decomposition:
- Package armaria_stack_pkg holds:
  - address-map constants (stack tops and bottoms, EMPTY_SP)
  - stack_op encoding: STACK_NONE, STACK_PUSH, STACK_POP
  - DEPTH_WIDTH
- Sub-module sp_bank_entry, instantiated twice (user and privileged). It contains the SP register, depth counter, expected-next-SP check and range check. It outputs fault strobes to the top, which owns the sticky flags and the PC.

Test Plan:
- Reset asserted mid-push, deasserted -> current_PC = 0, current_SP = 32'hffffffff, stack_depth = 0, all flags 0, both banks empty.
- User mode, push with next_SP_in = 8191, then push with 8190, then pop with 8191 -> SP sequence 8191, 8190, 8191; depth 1, 2, 1; no faults.
- Privileged mode, 2048 pushes with correct next_SP, then one more push -> SP = 4096, depth = 2048, stack_overflow = 1, one-cycle fault_pulse, SP unchanged.
- User bank empty, pop -> stack_underflow = 1, depth 0. Then push with next_SP_in = 8000 (expected 8191) -> sp_mismatch = 1, SP = 8000, depth 1.
- sp_write_en with data 6000 in user mode, simultaneous push -> write rejected, sp_mismatch = 1, SP unchanged, push ignored. Then write 7000 -> SP 7000, depth 1192.
- enable = 0 with branch_taken = 1, target 100 -> PC holds. enable = 1 -> PC = 100 next cycle. clear_faults -> all sticky flags 0.
